invader_engine_ctrl: RTL
========================

Name: invader_engine_ctrl

Overview:
- Parametrised next-generation game controller for the invader game: owns the game-state FSM, the row-weighted score and the enemy-shooter selection.
- Generalised to an N_ROWS x N_COLS enemy grid.
- Latches win/lose outcomes until restart.
- Selects only live shooters through a bounded scan and emits a one-cycle fire strobe with row/column coordinates.

Parameters:
- N_COLS, 13, enemies per row.
- N_ROWS, 5, enemy rows; row 0 is the top row.
- FIRE_DELAY, 1000000, clocks between shot attempts (>= 2).
- SCORE_W, 10, score width.
- LFSR_SEED, 16'hACE1, non-zero seed of the internal 16-bit LFSR.
- FIRE_STEP, 8192, per-kill delay reduction (used only with SPEEDUP_EN).
- FIRE_MIN, 100000, delay floor (used only with SPEEDUP_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enemy_vivos  in  N_ROWS*N_COLS  alive mask; bit i = row i/N_COLS, col i%N_COLS
- jogador_vivo  in  1  player alive
- vitoria_enemy  in  1  enemies reached the player line
- btn_D  in  1  restart button, active-low
- restart  out  1  combinational reset OR NOT btn_D; broadcast to the game
- score  out  SCORE_W  registered, row-weighted score
- estado_jogo  out  2  1 = running, 2 = player won, 3 = player lost
- tiro_valid  out  1  one-cycle fire strobe
- tiro_col  out  clog2(N_COLS)  shooter column, valid with tiro_valid and held afterwards
- tiro_row  out  clog2(N_ROWS)  shooter row, same timing as tiro_col

Behaviour:
- Internal reset is `restart` (reset OR NOT btn_D), sampled synchronously. It may occur mid-game or mid-scan and aborts everything immediately.
- Reset values:
  - FSM = RUN; estado_jogo = 1; score = 0
  - tiro_valid = 0; tiro_col = 0; tiro_row = 0
  - fire counter = 0; LFSR = LFSR_SEED
- FSM states:
  - RUN → LOSE when vitoria_enemy = 1 or jogador_vivo = 0.
  - RUN → WIN when enemy_vivos is all zero.
  - If both conditions hold in the same cycle, LOSE wins.
  - WIN and LOSE are sticky until restart, even if the inputs change.
  - estado_jogo is registered and reflects the FSM state 1 cycle after the triggering input.
- Score:
  - Each cycle in RUN: score <= sum over dead enemies of (N_ROWS - row). Top row is worth N_ROWS points, bottom row 1.
  - Saturates at 2^SCORE_W - 1.
  - Frozen (not updated) in WIN/LOSE.
  - Latency: 1 cycle from the enemy_vivos change.
- LFSR: 16-bit Fibonacci LFSR with taps 16,14,13,11; advances every cycle in all states.
- Shooter sub-FSM, active only in RUN:
  - WAIT: fire counter increments each cycle. At FIRE_DELAY-1:
    - Load start index = LFSR[IDX_W-1:0], with IDX_W = clog2(N_ROWS*N_COLS).
    - Subtract N_ROWS*N_COLS once if the value is >= N_ROWS*N_COLS (no divider).
    - Derive start row/col, counter = 0, go to SCAN.
  - SCAN: tests one index per cycle.
    - If the enemy at that index is alive: drive tiro_row/tiro_col, pulse tiro_valid for 1 cycle, go to WAIT.
    - Otherwise advance index, col and row. col wraps at N_COLS and increments row; row wraps at N_ROWS to index 0.
    - Row/col are tracked incrementally; no division.
    - If N_ROWS*N_COLS indices are tested with no hit, return to WAIT with no strobe.
  - WAIT restarts its counter at 0 on entry.
  - Leaving RUN forces the shooter to WAIT with tiro_valid = 0.
- tiro_valid never asserts outside RUN or during restart.
- tiro_col/tiro_row hold their last value between strobes.
- Shot latency: FIRE_DELAY cycles to SCAN entry, plus (number of dead enemies skipped + 1) cycles.

Optional Feature:
- Macro SPEEDUP_EN.
- Defined: the effective delay is max(FIRE_MIN, FIRE_DELAY - kills*FIRE_STEP), where kills = number of zero bits in enemy_vivos. It is recomputed on each WAIT entry, so firing speeds up as enemies die.
- Undefined: the delay is always FIRE_DELAY, and FIRE_STEP/FIRE_MIN are unused.

Test Plan (N_COLS = 4, N_ROWS = 2, FIRE_DELAY = 8 unless noted):
- Reset: pulse reset, all alive → estado_jogo = 1, score = 0, tiro_valid = 0. First tiro_valid pulse arrives between 9 and 17 cycles later with an in-range row/col.
- Score: kill bit 1 (row 0), then bit 6 (row 1) → score = 2, then 3, each 1 cycle after the mask change. Kill all → score = 12, estado_jogo = 2 next cycle and held after the mask is restored.
- Priority: clear enemy_vivos and drop jogador_vivo in the same cycle → estado_jogo = 3. Score frozen; no further tiro_valid pulses.
- Live-only shots: only bit 5 alive → every tiro_valid has tiro_row = 1, tiro_col = 1. Run 20 shots and check none has other coordinates.
- Restart: hold btn_D = 0 mid-SCAN → restart = 1 the same cycle, tiro_valid = 0, estado_jogo returns to 1, score = 0; counter restarts after release.
- SPEEDUP_EN (FIRE_DELAY = 40, FIRE_STEP = 8, FIRE_MIN = 16, 3 kills) → WAIT duration is 16 cycles. Without the macro → 40 cycles.

Source files
------------

// File: rtl/invader_engine_ctrl.sv
// rtl/invader_engine_ctrl.sv - invader game FSM, row-weighted score and live-shooter selection.
// Optional macro SPEEDUP_EN: shot delay shrinks with each kill down to FIRE_MIN.
module invader_engine_ctrl #(
   parameter int          N_COLS     = 13,
   parameter int          N_ROWS     = 5,
   parameter int          FIRE_DELAY = 1000000,
   parameter int          SCORE_W    = 10,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter int          FIRE_STEP  = 8192,
   parameter int          FIRE_MIN   = 100000,
   localparam int         N_EN       = N_ROWS * N_COLS,
   localparam int         COL_W      = (N_COLS > 1) ? $clog2(N_COLS) : 1,
   localparam int         ROW_W      = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_EN-1:0]    enemy_vivos,
   input  logic               jogador_vivo,
   input  logic               vitoria_enemy,
   input  logic               btn_D,
   output logic               restart,
   output logic [SCORE_W-1:0] score,
   output logic [1:0]         estado_jogo,
   output logic               tiro_valid,
   output logic [COL_W-1:0]   tiro_col,
   output logic [ROW_W-1:0]   tiro_row
);

   localparam int IDX_W   = (N_EN > 1) ? $clog2(N_EN) : 1;
   localparam int DLY_MAX = (FIRE_DELAY > FIRE_MIN) ? FIRE_DELAY : FIRE_MIN;
   localparam int CNT_W   = $clog2(DLY_MAX + 1);
   localparam int SCORE_MAX = (1 << SCORE_W) - 1;

   generate
      if (FIRE_DELAY < 2 || FIRE_MIN < 1 || FIRE_STEP < 0 || LFSR_SEED == 16'h0) begin : g_bad_cfg
         $error("invader_engine_ctrl: invalid fire timing or LFSR seed parameters");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_RUN  = 2'd1,
      ST_WIN  = 2'd2,
      ST_LOSE = 2'd3
   } game_t;

   typedef enum logic {
      SH_WAIT = 1'b0,
      SH_SCAN = 1'b1
   } shoot_t;

   game_t              state_q, state_d;
   shoot_t             sh_q, sh_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [IDX_W:0]     scan_cnt_q, scan_cnt_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic               tiro_valid_q, tiro_valid_d;
   logic [ROW_W-1:0]   tiro_row_q, tiro_row_d;
   logic [COL_W-1:0]   tiro_col_q, tiro_col_d;
   logic [CNT_W-1:0]   dly_m1;
   logic [CNT_W-1:0]   dly_entry;

   assign restart = reset | ~btn_D;

   // Game FSM: state register
   always_ff @(posedge clk) begin
      if (restart) state_q <= ST_RUN;
      else         state_q <= state_d;
   end

   // Game FSM: next state; LOSE has priority over WIN, both sticky
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (vitoria_enemy || !jogador_vivo) state_d = ST_LOSE;
            else if (enemy_vivos == '0)         state_d = ST_WIN;
         end
         default: state_d = state_q;
      endcase
   end

   // Game FSM: outputs
   always_comb begin
      estado_jogo = 2'd1;
      case (state_q)
         ST_WIN:  estado_jogo = 2'd2;
         ST_LOSE: estado_jogo = 2'd3;
         default: estado_jogo = 2'd1;
      endcase
   end

   always_comb begin
      int sum;
      sum = 0;
      for (int r = 0; r < N_ROWS; r++) begin
         for (int c = 0; c < N_COLS; c++) begin
            if (!enemy_vivos[r*N_COLS + c]) sum = sum + (N_ROWS - r);
         end
      end
      score_d = score_q;
      if (state_q == ST_RUN) begin
         if (sum > SCORE_MAX) score_d = SCORE_W'(SCORE_MAX);
         else                 score_d = SCORE_W'(sum);
      end
   end

   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

`ifdef SPEEDUP_EN
   logic [CNT_W-1:0] delay_q, delay_d;

   always_comb begin
      int kills;
      int dly_i;
      kills = 0;
      for (int i = 0; i < N_EN; i++) begin
         if (!enemy_vivos[i]) kills = kills + 1;
      end
      dly_i = FIRE_DELAY - kills * FIRE_STEP;
      if (dly_i < FIRE_MIN) dly_i = FIRE_MIN;
      dly_entry = CNT_W'(dly_i);
   end

   // Delay is latched on each WAIT entry so a scan in flight cannot change it
   always_comb begin
      delay_d = delay_q;
      if (sh_d == SH_WAIT && sh_q == SH_SCAN) delay_d = dly_entry;
   end

   always_ff @(posedge clk) begin
      if (restart) delay_q <= dly_entry;
      else         delay_q <= delay_d;
   end

   assign dly_m1 = delay_q - CNT_W'(1);
`else
   assign dly_entry = CNT_W'(FIRE_DELAY);
   assign dly_m1    = dly_entry - CNT_W'(1);
`endif

   logic [IDX_W-1:0] raw_idx, start_idx;
   logic [ROW_W-1:0] start_row;
   logic [COL_W-1:0] start_col;

   // Single conditional subtract folds the LFSR value into range; row/col found by comparison
   always_comb begin
      raw_idx   = lfsr_q[IDX_W-1:0];
      start_idx = raw_idx;
      if (int'(raw_idx) >= N_EN) start_idx = raw_idx - IDX_W'(N_EN);
      start_row = '0;
      start_col = COL_W'(start_idx);
      for (int r = 1; r < N_ROWS; r++) begin
         if (int'(start_idx) >= r * N_COLS) begin
            start_row = ROW_W'(r);
            start_col = COL_W'(int'(start_idx) - r * N_COLS);
         end
      end
   end

   always_comb begin
      sh_d         = sh_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      scan_cnt_d   = scan_cnt_q;
      row_d        = row_q;
      col_d        = col_q;
      tiro_valid_d = 1'b0;
      tiro_row_d   = tiro_row_q;
      tiro_col_d   = tiro_col_q;
      if (state_d != ST_RUN) begin
         sh_d  = SH_WAIT;
         cnt_d = '0;
      end else begin
         case (sh_q)
            SH_WAIT: begin
               if (cnt_q == dly_m1) begin
                  sh_d       = SH_SCAN;
                  cnt_d      = '0;
                  idx_d      = start_idx;
                  row_d      = start_row;
                  col_d      = start_col;
                  scan_cnt_d = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            SH_SCAN: begin
               if (enemy_vivos[idx_q]) begin
                  tiro_valid_d = 1'b1;
                  tiro_row_d   = row_q;
                  tiro_col_d   = col_q;
                  sh_d         = SH_WAIT;
                  cnt_d        = '0;
               end else if (int'(scan_cnt_q) == N_EN - 1) begin
                  sh_d  = SH_WAIT;
                  cnt_d = '0;
               end else begin
                  scan_cnt_d = scan_cnt_q + (IDX_W+1)'(1);
                  if (int'(col_q) == N_COLS - 1) begin
                     col_d = '0;
                     if (int'(row_q) == N_ROWS - 1) begin
                        row_d = '0;
                        idx_d = '0;
                     end else begin
                        row_d = row_q + ROW_W'(1);
                        idx_d = idx_q + IDX_W'(1);
                     end
                  end else begin
                     col_d = col_q + COL_W'(1);
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
            default: sh_d = SH_WAIT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (restart) begin
         score_q      <= '0;
         lfsr_q       <= LFSR_SEED;
         sh_q         <= SH_WAIT;
         cnt_q        <= '0;
         idx_q        <= '0;
         scan_cnt_q   <= '0;
         row_q        <= '0;
         col_q        <= '0;
         tiro_valid_q <= 1'b0;
         tiro_row_q   <= '0;
         tiro_col_q   <= '0;
      end else begin
         score_q      <= score_d;
         lfsr_q       <= lfsr_d;
         sh_q         <= sh_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         scan_cnt_q   <= scan_cnt_d;
         row_q        <= row_d;
         col_q        <= col_d;
         tiro_valid_q <= tiro_valid_d;
         tiro_row_q   <= tiro_row_d;
         tiro_col_q   <= tiro_col_d;
      end
   end

   // Mask the strobe combinationally so it is never seen while restart is held
   assign tiro_valid = tiro_valid_q & ~restart;
   assign score      = score_q;
   assign tiro_row   = tiro_row_q;
   assign tiro_col   = tiro_col_q;

endmodule
